// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and constants for the ALU scheduler.
package alu_sched_pkg;
    typedef enum logic [2:0] {
        SUM = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3, MOD = 3'd4, MOV = 3'd5
    } alu_op_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;
    localparam logic [2:0] OP_LAST = 3'd5;
    localparam int FLAG_W = 4;
endpackage

// File: rtl/alu_sched_arb.sv
// alu_sched_arb: two-input arbiter; ALU_SCHED_RR_EN selects round-robin, else req0 has fixed priority.
module alu_sched_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic v0,
    input  logic v1,
    output logic g0,
    output logic g1,
    output logic gid
);
`ifdef ALU_SCHED_RR_EN
    logic ptr;
    always_ff @(posedge clk)
        if (!rst_n) ptr <= 1'b1;
        else if (en && (v0 || v1)) ptr <= gid;
    assign gid = (v0 && v1) ? ~ptr : v1;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n};
    assign gid = ~v0;
`endif
    assign g0 = en & v0 & ~gid;
    assign g1 = en & v1 & gid;
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one combinational ALU between two requesters, one op in flight.
// Arbitration is round-robin when ALU_SCHED_RR_EN is defined, fixed req0 priority otherwise.
module alu_scheduler #(
    parameter int N  = 32,
    parameter int FW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [N-1:0]  req0_a,
    input  logic [N-1:0]  req0_b,
    input  logic [2:0]    req0_op,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [N-1:0]  req1_a,
    input  logic [N-1:0]  req1_b,
    input  logic [2:0]    req1_op,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [N-1:0]  rsp_result,
    output logic [FW-1:0] rsp_flags,
    output logic          rsp_err,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [2:0]    alu_ctrl,
    input  logic [N-1:0]  alu_result,
    input  logic [FW-1:0] alu_flags,
    output logic [CW-1:0] op_count
);
    import alu_sched_pkg::*;

    sched_state_t  state, nxt;
    logic [N-1:0]  a_q, b_q, res_q;
    logic [FW-1:0] flg_q;
    logic [2:0]    op_q;
    logic          gid_q, err_q, gid, accept, rsp_hs, ill;
    logic [CW-1:0] cnt;

    alu_sched_arb u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == IDLE && rst_n),
        .v0   (req0_valid),
        .v1   (req1_valid),
        .g0   (req0_ready),
        .g1   (req1_ready),
        .gid  (gid)
    );

    assign accept = req0_ready | req1_ready;
    assign ill    = op_q > OP_LAST;
    assign rsp_hs = state == RESP && (gid_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        nxt = state;
        nxt = (state == IDLE) ? (accept ? EXEC : IDLE) :
              (state == EXEC) ? RESP : (rsp_hs ? IDLE : RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            gid_q <= 1'b0;
            res_q <= '0;
            flg_q <= '0;
            err_q <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                a_q   <= gid ? req1_a : req0_a;
                b_q   <= gid ? req1_b : req0_b;
                op_q  <= gid ? req1_op : req0_op;
                gid_q <= gid;
            end
            if (state == EXEC) begin
                res_q <= ill ? '0 : alu_result;
                flg_q <= ill ? '0 : alu_flags;
                err_q <= ill;
            end
            if (rsp_hs) cnt <= cnt + 1'b1;
        end
    end

    // Illegal opcodes are never presented to the ALU.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ill ? 3'd0 : op_q;
    assign rsp0_valid = state == RESP && !gid_q;
    assign rsp1_valid = state == RESP && gid_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;
    assign rsp_err    = err_q;
    assign op_count   = cnt;
endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencer and arbiter that shares the single combinational ALU between two requesters (req0, req1). It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode inputs from registered copies. It captures the ALU result and flags, then returns them to the granted requester over a valid/ready response channel. It sits between the issue logic and the ALU top level in the CPU datapath.

## Interface
- N, default 32: operand/result width; must match the ALU instance.
- FW, default 4: flag width, ordered N,Z,C,V as the ALU produces them.
- CW, default 16: width of the completed-operation counter.
- clk  in  1: clock, rising edge.
- rst_n  in  1: reset. Synchronous and active-low, sampled on the rising edge of clk.
- reqK_valid  in  1 (K=0,1): requester K presents an operation.
- reqK_ready  out  1: the scheduler accepts requester K's operation this cycle.
- reqK_a, reqK_b  in  N: operands.
- reqK_op  in  3: ALU control code. 0 sum, 1 sub, 2 mul, 3 div, 4 mod, 5 mov; 6 and 7 are illegal.
- rspK_valid  out  1: response for requester K is available.
- rspK_ready  in  1: requester K takes the response.
- rsp_result  out  N: shared response data, meaningful only while a rspK_valid is high.
- rsp_flags  out  FW: shared response flags.
- rsp_err  out  1: the completed operation had an illegal opcode.
- alu_a, alu_b  out  N: drive the ALU inputs.
- alu_ctrl  out  3: drives the ALU control input.
- alu_result  in  N: ALU result, combinational from alu_a, alu_b and alu_ctrl.
- alu_flags  in  FW: ALU flags, combinational.
- op_count  out  CW: number of completed (retired) operations; wraps modulo 2^CW.

## Operation
- FSM states:
  - IDLE: may accept a request.
  - EXEC: ALU is driven from latched registers.
  - RESP: response is held.
- IDLE:
  - reqK_ready = 1 only for the granted requester, and only when reqK_valid is high. Both readys are low in every other state.
  - On acceptance, latch a, b, op and grant id, then go to EXEC.
- EXEC:
  - alu_a, alu_b and alu_ctrl come from the latches.
  - At the end of the cycle, register alu_result and alu_flags into the response registers.
  - If the opcode is 6 or 7: register result 0, flags 0, err 1, and drive alu_ctrl to 0.
  - Go to RESP.
- RESP:
  - rspK_valid = 1 for the latched grant id only.
  - Result, flags and err are held stable until rspK_ready.
  - On rspK_valid & rspK_ready: op_count increments and the FSM returns to IDLE.
- Outside EXEC, alu_a, alu_b and alu_ctrl hold their last latched values (no toggling).
- Arbitration in IDLE, when both requesters are valid, is set by the configuration macro. A single valid requester is always granted.
- Responses never reorder; at most one operation is in flight.
- A requester may drop valid before acceptance. Only an accepted operation is committed.
- Reset mid-operation: the FSM returns to IDLE and the in-flight operation is discarded with no response.

## Timing
- Reset values:
  - FSM = IDLE.
  - req0_ready = req1_ready = 0 during reset.
  - rsp0_valid = rsp1_valid = 0.
  - rsp_result = 0, rsp_flags = 0, rsp_err = 0.
  - alu_a = alu_b = 0, alu_ctrl = 0.
  - op_count = 0.
  - Round-robin last-grant pointer = 1, so req0 wins first.
- Latency: accept on cycle T, EXEC on T+1, rspK_valid high from T+2.
  - If rspK_ready is high at T+2, the next accept can happen at T+3.
  - Peak throughput is one operation per 3 cycles.
- reqK_ready is combinational from reqK_valid, the state and the pointer. Inputs are sampled on the accept edge.
- op_count wraps from 2^CW-1 to 0 without any flag.

## Configuration
- ALU_SCHED_RR_EN:
  - Defined: round-robin arbitration. The pointer updates on each acceptance to the accepted id. When both are valid, the requester not equal to the pointer wins.
  - Undefined: fixed priority, req0 always wins. The pointer register is not instantiated.

## Structure
- Package alu_sched_pkg:
  - alu_op_t enum: SUM=0, SUB=1, MUL=2, DIV=3, MOD=4, MOV=5.
  - sched_state_t enum: IDLE, EXEC, RESP.
  - Constant OP_LAST = 5, used for the illegal-op check.
  - FLAG_W = 4.
- Sub-module alu_sched_arb:
  - Two-input arbiter returning grant and grant id.
  - Contains the round-robin pointer under the macro.

## Test plan
- Single op: req0 with a=7, b=5, op=0, then rsp0_ready=1 at T+2 -> rsp0_valid at T+2, result 12, flags 0, op_count 1.
- Flags: req1 with a=3, b=5, op=1 -> result 0xFFFFFFFE, N=1, rsp1_valid only, rsp0_valid stays 0.
- Contention: both valid continuously with op=5, responses taken immediately.
  - RR_EN defined -> grants 0,1,0,1.
  - RR_EN undefined -> 0,0,0,0.
- Backpressure: hold rsp0_ready=0 for 5 cycles -> rsp_result, rsp_flags and rsp_err stable, both readys 0, op_count unchanged until the handshake.
- Illegal op: op=6 -> rsp_err=1, result 0, flags 0, alu_ctrl=0 during EXEC.
- Reset in EXEC: rst_n=0 for 1 cycle -> no rspK_valid, op_count 0, next request accepted normally.
